uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer.sv | 109 ++++++++++
 tb/tb_uart_tx_framer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// Serial UART transmit framer: start bit, LSB-first data, optional parity, one or two stop bits.
// Accepts a new word in IDLE or in the final stop-bit cycle so frames can run back to back.
module uart_tx_framer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  FRAME_DONE
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    START  = 6'b000010,
    DATA   = 6'b000100,
    PARITY = 6'b001000,
    STOP1  = 6'b010000,
    STOP_2 = 6'b100000
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic                    stop2_q;
  logic                    final_stop;
  logic                    accept;
  logic                    tx_nxt;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign final_stop = (state == STOP_2) || ((state == STOP1) && !stop2_q);
  assign accept     = DATA_VALID && ((state == IDLE) || final_stop);

  always_comb begin
    state_nxt = IDLE;
    cnt_nxt   = '0;
    case (state)
      IDLE:   state_nxt = accept ? START : IDLE;
      START:  state_nxt = DATA;
      DATA: begin
        if (cnt == CNT_LAST) begin
          state_nxt = par_en_q ? PARITY : STOP1;
        end else begin
          state_nxt = DATA;
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      PARITY: state_nxt = STOP1;
      STOP1:  state_nxt = stop2_q ? STOP_2 : (accept ? START : IDLE);
      STOP_2: state_nxt = accept ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it;
  // data_q is stable whenever the next state is DATA or PARITY.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = data_q[cnt_nxt];
      PARITY:  tx_nxt = parity_bit(data_q, par_typ_q);
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      cnt        <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      TX_OUT     <= 1'b1;
      Busy       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        stop2_q   <= STOP2;
      end
      TX_OUT     <= tx_nxt;
      Busy       <= (state_nxt != IDLE);
      // stop2_q only reloads on entry to START, so it still describes this frame here
      FRAME_DONE <= (state_nxt == STOP_2) || ((state_nxt == STOP1) && !stop2_q);
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: queue-based line model checked every cycle, plus literal frame checks.
// A second DATA_WIDTH=5 instance covers the narrow-word build.
module tb_uart_tx_framer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID, PAR_EN, PAR_TYP, STOP2;
  logic       TX_OUT, Busy, FRAME_DONE;

  logic [4:0] p5;
  logic       dv5;
  logic       zero5 = 1'b0;
  logic       tx5, busy5, done5;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  // expected {tx, busy, done} for the cycle currently on the line, plus future cycles
  logic       exp_tx = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;
  logic [2:0] mq[$];

  always #5 CLK = ~CLK;

  uart_tx_framer #(.DATA_WIDTH(8)) u_dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .TX_OUT(TX_OUT), .Busy(Busy), .FRAME_DONE(FRAME_DONE)
  );

  uart_tx_framer #(.DATA_WIDTH(5)) u_dut5 (
    .CLK(CLK), .RST(RST), .P_DATA(p5), .DATA_VALID(dv5),
    .PAR_EN(zero5), .PAR_TYP(zero5), .STOP2(zero5),
    .TX_OUT(tx5), .Busy(busy5), .FRAME_DONE(done5)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
    mq.push_back(3'b010);
    for (int i = 0; i < 8; i++) mq.push_back({d[i], 2'b10});
    if (pe) mq.push_back({(^d) ^ pt, 2'b10});
    mq.push_back({2'b11, ~s2});
    if (s2) mq.push_back(3'b111);
  endtask

  // Line model: a frame is a list of bits queued on acceptance and played out one per cycle.
  initial begin
    logic [2:0] e;
    forever begin
      @(posedge CLK);
      if (!RST) begin
        mq.delete();
        e = 3'b100;
      end else begin
        if (DATA_VALID && (!exp_busy || exp_done)) push_frame(P_DATA, PAR_EN, PAR_TYP, STOP2);
        e = (mq.size() > 0) ? mq.pop_front() : 3'b100;
      end
      {exp_tx, exp_busy, exp_done} = e;
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (check_en)
        chk($sformatf("cycle@%0t", $time), {29'd0, TX_OUT, Busy, FRAME_DONE},
            {29'd0, exp_tx, exp_busy, exp_done});
    end
  end

  // Starts at a negedge: requests d, then samples n cycles. At sample 1 P_DATA becomes d2
  // (and with tamper the config inputs flip); DATA_VALID drops at drop_at and pulses at pulse_at.
  task automatic run_frame(input string name, input logic [7:0] d, input logic pe, input logic pt,
                           input logic s2, input logic [7:0] d2, input logic tamper, input int n,
                           input int drop_at, input int pulse_at, input logic [31:0] lit_tx,
                           input logic [31:0] lit_bz, input logic [31:0] lit_dn);
    logic [31:0] tx, bz, dn, mtx;
    tx = '0; bz = '0; dn = '0; mtx = '0;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; DATA_VALID = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge CLK);
      tx  = {tx[30:0], TX_OUT};
      bz  = {bz[30:0], Busy};
      dn  = {dn[30:0], FRAME_DONE};
      mtx = {mtx[30:0], exp_tx};
      if (i == 1) begin
        P_DATA = d2;
        if (tamper) {PAR_EN, PAR_TYP, STOP2} = ~{pe, pt, s2};
      end
      if (i == drop_at) DATA_VALID = 1'b0;
      if (pulse_at > 0 && i == pulse_at) DATA_VALID = 1'b1;
      if (pulse_at > 0 && i == pulse_at + 1) DATA_VALID = 1'b0;
    end
    chk({name, "_tx"}, tx, lit_tx);
    chk({name, "_busy"}, bz, lit_bz);
    chk({name, "_done"}, dn, lit_dn);
    chk({name, "_model"}, mtx, lit_tx);
  endtask

  initial begin
    logic [31:0] t5, b5, d5;
    RST = 1'b0; DATA_VALID = 1'b1; P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    p5 = 5'h00; dv5 = 1'b0;
    @(negedge CLK);
    check_en = 1'b1;
    chk("reset_state", {29'd0, TX_OUT, Busy, FRAME_DONE}, 32'b100);
    chk("reset_state_w5", {29'd0, tx5, busy5, done5}, 32'b100);
    RST = 1'b1; DATA_VALID = 1'b0;
    @(negedge CLK);

    // 0xA5, no parity, one stop
    run_frame("a5_basic", 8'hA5, 0, 0, 0, 8'hA5, 0, 11, 1, 0,
              32'b01010010111, 32'b11111111110, 32'b00000000010);
    // even then odd parity
    run_frame("a5_even", 8'hA5, 1, 0, 0, 8'hA5, 0, 12, 1, 0,
              32'b010100101011, 32'b111111111110, 32'b000000000010);
    run_frame("a5_odd", 8'hA5, 1, 1, 0, 8'hA5, 0, 12, 1, 0,
              32'b010100101111, 32'b111111111110, 32'b000000000010);
    // zeros, odd parity, two stop bits
    run_frame("zero_2stop", 8'h00, 1, 1, 1, 8'h00, 0, 13, 1, 0,
              32'b0000000001111, 32'b1111111111110, 32'b0000000000010);
    // back to back: 0x55 then 0x3C with DATA_VALID held
    run_frame("b2b", 8'h55, 0, 0, 0, 8'h3C, 0, 21, 11, 0,
              32'b010101010100011110011, 32'h1FFFFE, 32'b000000000100000000010);
    // inputs disturbed and a stray request during DATA
    run_frame("tamper", 8'hA5, 0, 0, 0, 8'h5A, 1, 11, 1, 4,
              32'b01010010111, 32'b11111111110, 32'b00000000010);

    // reset during the 4th data bit, with a request held through reset
    P_DATA = 8'hC3; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; DATA_VALID = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLK);
      if (i == 1) DATA_VALID = 1'b0;
    end
    RST = 1'b0; DATA_VALID = 1'b1;
    @(negedge CLK);
    chk("rst_abort", {29'd0, TX_OUT, Busy, FRAME_DONE}, 32'b100);
    RST = 1'b1; DATA_VALID = 1'b0;
    @(negedge CLK);
    chk("rst_stays_idle", {29'd0, TX_OUT, Busy, FRAME_DONE}, 32'b100);
    run_frame("after_rst", 8'hC3, 0, 0, 0, 8'hC3, 0, 11, 1, 0,
              32'b01100001111, 32'b11111111110, 32'b00000000010);

    // DATA_WIDTH=5 build, 0x15
    t5 = '0; b5 = '0; d5 = '0;
    p5 = 5'h15; dv5 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      t5 = {t5[30:0], tx5};
      b5 = {b5[30:0], busy5};
      d5 = {d5[30:0], done5};
      if (i == 1) begin
        dv5 = 1'b0;
        p5  = 5'h0A;
      end
    end
    chk("w5_tx", t5, 32'b01010111);
    chk("w5_busy", b5, 32'b11111110);
    chk("w5_done", d5, 32'b00000010);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      P_DATA     = 8'($urandom);
      PAR_EN     = 1'($urandom_range(0, 1));
      PAR_TYP    = 1'($urandom_range(0, 1));
      STOP2      = 1'($urandom_range(0, 1));
      DATA_VALID = ($urandom_range(0, 2) == 0);
      RST        = ($urandom_range(0, 79) != 0);
      @(negedge CLK);
    end
    RST = 1'b1; DATA_VALID = 1'b0;
    repeat (15) @(negedge CLK);
    chk("final_idle", {29'd0, TX_OUT, Busy, FRAME_DONE}, 32'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
